// File: rtl/io_fifo_server.sv
// Buffered server side of the character I/O channel: an rx-fed input FIFO for getc and a
// putc-fed output FIFO draining to the transmitter, with overrun flag and push/done handshake.
module io_fifo_server #(
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned IN_DEPTH  = 16,
    parameter int unsigned OUT_DEPTH = 16,
    localparam int unsigned IN_AW    = $clog2(IN_DEPTH),
    localparam int unsigned IN_CW    = $clog2(IN_DEPTH + 1),
    localparam int unsigned OUT_AW   = $clog2(OUT_DEPTH),
    localparam int unsigned OUT_CW   = $clog2(OUT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              getc_pop,
    output logic              getc_en,
    output logic [CHAR_W-1:0] getc_char,
    output logic              inbuf_full,
    input  logic              putc_push,
    input  logic [CHAR_W-1:0] putc_char,
    output logic              putc_push_done,
    input  logic              rx_valid,
    input  logic [CHAR_W-1:0] rx_char,
    output logic              rx_overrun,
    input  logic              overrun_clr,
    output logic              tx_valid,
    output logic [CHAR_W-1:0] tx_char,
    input  logic              tx_ready,
    output logic [IN_CW-1:0]  in_count,
    output logic [OUT_CW-1:0] out_count
);

    localparam logic [IN_CW-1:0]  InFull  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OutFull = OUT_CW'(OUT_DEPTH);

    typedef enum logic [0:0] {StIdle, StDone} push_state_e;

    // ---------------- input FIFO ----------------
    logic [CHAR_W-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wptr_q, in_rptr_q;
    logic [IN_CW-1:0]  in_count_q, in_count_d;
    logic [CHAR_W-1:0] in_hold_q;
    logic              overrun_q, overrun_d;
    logic              in_pop, in_wr, in_drop;

    assign in_pop  = getc_pop && (in_count_q != '0);
    assign in_wr   = rx_valid && ((in_count_q != InFull) || in_pop);
    assign in_drop = rx_valid && !in_wr;

    always_comb begin
        in_count_d = in_count_q;
        case ({in_wr, in_pop})
            2'b10:   in_count_d = in_count_q + IN_CW'(1);
            2'b01:   in_count_d = in_count_q - IN_CW'(1);
            default: in_count_d = in_count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        overrun_d = in_drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (in_wr) in_mem[in_wptr_q] <= rx_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_count_q <= '0;
            in_hold_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (in_wr) in_wptr_q <= in_wptr_q + IN_AW'(1);
            if (in_pop) begin
                in_rptr_q <= in_rptr_q + IN_AW'(1);
                in_hold_q <= in_mem[in_rptr_q];
            end
            in_count_q <= in_count_d;
            overrun_q  <= overrun_d;
        end
    end

    assign getc_en    = (in_count_q != '0);
    // Last popped value is presented while empty so the head never shows stale slots.
    assign getc_char  = getc_en ? in_mem[in_rptr_q] : in_hold_q;
    assign inbuf_full = (in_count_q == InFull);
    assign in_count   = in_count_q;
    assign rx_overrun = overrun_q;

    // ---------------- output FIFO ----------------
    logic [CHAR_W-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wptr_q, out_rptr_q;
    logic [OUT_CW-1:0] out_count_q, out_count_d;
    logic [CHAR_W-1:0] out_hold_q;
    logic              out_push, tx_pop;
    push_state_e       state_q, state_d;

    // Acceptance looks only at the registered count, so a same-cycle tx pop cannot free a slot.
    always_comb begin
        state_d        = state_q;
        out_push       = 1'b0;
        putc_push_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (putc_push && (out_count_q != OutFull)) begin
                    out_push = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                putc_push_done = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_pop = tx_valid && tx_ready;

    always_comb begin
        out_count_d = out_count_q;
        case ({out_push, tx_pop})
            2'b10:   out_count_d = out_count_q + OUT_CW'(1);
            2'b01:   out_count_d = out_count_q - OUT_CW'(1);
            default: out_count_d = out_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wptr_q] <= putc_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_wptr_q  <= '0;
            out_rptr_q  <= '0;
            out_count_q <= '0;
            out_hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (out_push) out_wptr_q <= out_wptr_q + OUT_AW'(1);
            if (tx_pop) begin
                out_rptr_q <= out_rptr_q + OUT_AW'(1);
                out_hold_q <= out_mem[out_rptr_q];
            end
            out_count_q <= out_count_d;
        end
    end

    assign tx_valid  = (out_count_q != '0);
    assign tx_char   = tx_valid ? out_mem[out_rptr_q] : out_hold_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_io_fifo_server.sv
// Directed self-checking bench for io_fifo_server: instance a (IN 4, OUT 2) covers rx/getc,
// overrun and output stall; instance b (OUT 4) covers the held-push sequence.
module tb_io_fifo_server;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    int pulses;

    // instance a
    logic       getc_pop, putc_push, rx_valid, overrun_clr, tx_ready;
    logic [7:0] putc_char, rx_char;
    logic       a_getc_en, a_inbuf_full, a_done, a_overrun, a_tx_valid;
    logic [7:0] a_getc_char, a_tx_char;
    logic [2:0] a_in_count;
    logic [1:0] a_out_count;

    // instance b
    logic       b_putc_push, b_tx_ready;
    logic [7:0] b_putc_char;
    logic       b_getc_en, b_inbuf_full, b_done, b_overrun, b_tx_valid;
    logic [7:0] b_getc_char, b_tx_char;
    logic [1:0] b_in_count;
    logic [2:0] b_out_count;

    io_fifo_server #(.CHAR_W(8), .IN_DEPTH(4), .OUT_DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .getc_pop(getc_pop), .getc_en(a_getc_en), .getc_char(a_getc_char),
        .inbuf_full(a_inbuf_full),
        .putc_push(putc_push), .putc_char(putc_char), .putc_push_done(a_done),
        .rx_valid(rx_valid), .rx_char(rx_char), .rx_overrun(a_overrun),
        .overrun_clr(overrun_clr),
        .tx_valid(a_tx_valid), .tx_char(a_tx_char), .tx_ready(tx_ready),
        .in_count(a_in_count), .out_count(a_out_count)
    );

    io_fifo_server #(.CHAR_W(8), .IN_DEPTH(2), .OUT_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .getc_pop(1'b0), .getc_en(b_getc_en), .getc_char(b_getc_char),
        .inbuf_full(b_inbuf_full),
        .putc_push(b_putc_push), .putc_char(b_putc_char), .putc_push_done(b_done),
        .rx_valid(1'b0), .rx_char(8'h00), .rx_overrun(b_overrun),
        .overrun_clr(1'b0),
        .tx_valid(b_tx_valid), .tx_char(b_tx_char), .tx_ready(b_tx_ready),
        .in_count(b_in_count), .out_count(b_out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        getc_pop = 0; putc_push = 0; rx_valid = 0; overrun_clr = 0; tx_ready = 0;
        putc_char = 0; rx_char = 0;
        b_putc_push = 0; b_putc_char = 0; b_tx_ready = 0;
        tick();
        tick();
        check("reset getc_en", 32'(a_getc_en), 0);
        check("reset out_count", 32'(a_out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- input fill and overrun ----
        rx_valid = 1;
        rx_char = 8'h41;
        tick();
        check("rx first getc_en", 32'(a_getc_en), 1);
        check("rx first head", 32'(a_getc_char), 32'h41);
        for (int i = 1; i < 5; i++) begin
            rx_char = 8'(8'h41 + i);
            tick();
        end
        rx_valid = 0;
        check("fill in_count", 32'(a_in_count), 4);
        check("fill inbuf_full", 32'(a_inbuf_full), 1);
        check("fill overrun", 32'(a_overrun), 1);
        for (int i = 0; i < 4; i++) begin
            check("pop order", 32'(a_getc_char), 32'(8'h41 + i));
            getc_pop = 1;
            tick();
        end
        getc_pop = 0;
        check("drained getc_en", 32'(a_getc_en), 0);
        check("drained in_count", 32'(a_in_count), 0);
        check("empty head hold", 32'(a_getc_char), 32'h44);

        // empty FIFO: pop ignored, write happens
        getc_pop = 1;
        rx_valid = 1;
        rx_char = 8'h77;
        tick();
        check("empty wr+pop count", 32'(a_in_count), 1);
        check("empty wr+pop head", 32'(a_getc_char), 32'h77);
        rx_valid = 0;
        tick();
        getc_pop = 0;
        check("pop to empty", 32'(a_in_count), 0);

        // ---- full FIFO write plus pop ----
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        check("overrun clear", 32'(a_overrun), 0);
        rx_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rx_char = 8'(8'h50 + i);
            tick();
        end
        rx_char = 8'h5A;
        getc_pop = 1;
        tick();
        rx_valid = 0;
        getc_pop = 0;
        check("full wr+pop count", 32'(a_in_count), 4);
        check("full wr+pop overrun", 32'(a_overrun), 0);
        check("full wr+pop head", 32'(a_getc_char), 32'h51);
        getc_pop = 1;
        tick();
        tick();
        check("before last head", 32'(a_getc_char), 32'h53);
        tick();
        check("last out is 5A", 32'(a_getc_char), 32'h5A);
        tick();
        getc_pop = 0;
        check("empty after 5A", 32'(a_getc_en), 0);

        // ---- overrun clear collision ----
        rx_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rx_char = 8'(8'h60 + i);
            tick();
        end
        rx_char = 8'h64;
        overrun_clr = 1;
        tick();
        rx_valid = 0;
        check("drop beats clear", 32'(a_overrun), 1);
        tick();
        overrun_clr = 0;
        check("lone clear", 32'(a_overrun), 0);
        getc_pop = 1;
        repeat (4) tick();
        getc_pop = 0;

        // ---- output stall (OUT_DEPTH 2, tx_ready 0) ----
        putc_push = 1;
        putc_char = 8'h10;
        tick();
        check("push0 done", 32'(a_done), 1);
        check("push0 tx_valid", 32'(a_tx_valid), 1);
        putc_char = 8'h11;
        tick();
        check("push1 no done yet", 32'(a_done), 0);
        tick();
        check("push1 done", 32'(a_done), 1);
        check("out full", 32'(a_out_count), 2);
        putc_char = 8'h12;
        tick();
        tick();
        check("stall no done", 32'(a_done), 0);
        check("stall count", 32'(a_out_count), 2);
        check("tx head 10", 32'(a_tx_char), 32'h10);
        tx_ready = 1;
        tick();
        tx_ready = 0;
        check("pop does not admit push", 32'(a_done), 0);
        check("after pop count", 32'(a_out_count), 1);
        check("tx head 11", 32'(a_tx_char), 32'h11);
        tick();
        check("push2 done", 32'(a_done), 1);
        check("push2 count", 32'(a_out_count), 2);
        putc_push = 0;
        tx_ready = 1;
        tick();
        check("tx head 12", 32'(a_tx_char), 32'h12);
        tick();
        tx_ready = 0;
        check("tx drained", 32'(a_tx_valid), 0);
        check("tx hold 12", 32'(a_tx_char), 32'h12);

        // ---- held push on b ----
        pulses = 0;
        b_putc_char = 8'h20;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            b_putc_push = (cyc <= 5);
            check("held done pattern", 32'(b_done), 32'(cyc == 2 || cyc == 4 || cyc == 6));
            if (b_done) pulses++;
            tick();
        end
        b_putc_push = 0;
        check("held pulse count", 32'(pulses), 3);
        check("held out_count", 32'(b_out_count), 3);
        b_tx_ready = 1;
        for (int i = 3; i > 0; i--) begin
            check("b drain char", 32'(b_tx_char), 32'h20);
            tick();
            check("b drain count", 32'(b_out_count), 32'(i - 1));
        end
        b_tx_ready = 0;

        // ---- reset mid-operation ----
        rx_valid = 1;
        rx_char = 8'h99;
        putc_push = 1;
        putc_char = 8'h33;
        tick();
        rx_valid = 0;
        putc_push = 0;
        check("pre-reset getc_en", 32'(a_getc_en), 1);
        check("pre-reset done", 32'(a_done), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async getc_en", 32'(a_getc_en), 0);
        check("async getc_char", 32'(a_getc_char), 0);
        check("async done", 32'(a_done), 0);
        check("async tx_valid", 32'(a_tx_valid), 0);
        check("async tx_char", 32'(a_tx_char), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset in_count", 32'(a_in_count), 0);
        check("post-reset out_count", 32'(a_out_count), 0);
        check("post-reset done", 32'(a_done), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
